// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder datapath: rounding-mode
// encodings, exception flag bit positions and exponent range helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,  // round to nearest, ties to even
        RM_RTZ = 2'b01,  // round toward zero
        RM_RUP = 2'b10,  // round toward +infinity
        RM_RDN = 2'b11   // round toward -infinity
    } rmode_t;

    // Bit positions inside the 4-bit flag vector {of, uf, inexact, zero}
    localparam int FLG_OF   = 3;
    localparam int FLG_UF   = 2;
    localparam int FLG_NX   = 1;
    localparam int FLG_ZERO = 0;

    // Largest biased exponent of a finite number; all ones is reserved for infinity.
    function automatic int max_finite_exp(input int ew);
        return (1 << ew) - 2;
    endfunction

endpackage

// File: rtl/lead_zero_count.sv
// Combinational leading-zero counter. cnt equals W when the input is all zero.
module lead_zero_count #(
    parameter int W = 27
) (
    input  logic [W-1:0]             din,
    output logic [$clog2(W+1)-1:0]   cnt,
    output logic                     all_zero
);

    localparam int CW = $clog2(W+1);

    // Scan from LSB upward so the highest set bit decides the count last.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
        all_zero = (din == '0);
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Normalise-and-round stage of the floating-point adder. Three register
// stages: S1 normalises the raw sum, S2 rounds, S3 packs and checks overflow.
//
// Handshake: a beat transfers on a rising edge where in_valid & in_ready; a
// result transfers where out_valid & out_ready. The whole pipe advances
// together when adv = !out_valid | out_ready, and in_ready is exactly adv.
// While out_valid & !out_ready every stage, including the outputs, holds.
// Bubbles travel through the pipe and are not squeezed out.
module fp_norm_pipe
    import fp_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [EW-1:0]   es,
    input  logic            co,
    input  logic [MW+3:0]   ms,
    input  logic            sign,
    input  logic [1:0]      rmode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MW-1:0]   m,
    output logic [EW-1:0]   e,
    output logic            s_out,
    output logic [3:0]      flg
);

    localparam int W  = MW + 4;          // integer bit + fraction + G/R/S
    localparam int CW = $clog2(W + 1);   // leading-zero count width
    localparam int XW = EW + 2;          // signed working exponent width

    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
    localparam logic signed [XW-1:0] EXP_OF  = XW'((1 << EW) - 1);
    localparam logic [EW-1:0]        EMAX    = EW'(max_finite_exp(EW));

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // S1: normalise
    // ------------------------------------------------------------------
    logic [CW-1:0]          lz;
    logic                   lz_zero;
    logic [W-1:0]           n1_mant;
    logic signed [XW-1:0]   n1_exp;
    logic                   n1_zero;
    logic                   n1_uf;

    lead_zero_count #(.W(W)) u_lzc (
        .din      (ms),
        .cnt      (lz),
        .all_zero (lz_zero)
    );

    // Pick carry right-shift, exact zero, or leading-zero left-shift; flush tiny results.
    always_comb begin
        n1_mant = ms << lz;
        n1_exp  = $signed({2'b00, es}) - $signed({{(XW-CW){1'b0}}, lz});
        n1_zero = 1'b0;
        n1_uf   = 1'b0;
        if (co) begin
            // The carry becomes the new integer bit; the two dropped bits fold into sticky.
            n1_mant = {1'b1, ms[W-1:2], ms[1] | ms[0]};
            n1_exp  = $signed({2'b00, es}) + EXP_ONE;
        end else if (lz_zero) begin
            n1_mant = '0;
            n1_exp  = '0;
            n1_zero = 1'b1;
        end
        // No denormals: anything below the smallest normal exponent becomes zero.
        // The mantissa is kept so S2 still reports inexact from its G/R/S bits.
        if (!n1_zero && (n1_exp < EXP_ONE)) begin
            n1_uf   = 1'b1;
            n1_zero = 1'b1;
        end
    end

    logic                   s1_v;
    logic [W-1:0]           s1_mant;
    logic signed [XW-1:0]   s1_exp;
    logic                   s1_sign;
    rmode_t                 s1_rm;
    logic                   s1_zero;
    logic                   s1_uf;

    // S1 register: loads on adv, holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_mant <= '0;
            s1_exp  <= '0;
            s1_sign <= 1'b0;
            s1_rm   <= RM_RNE;
            s1_zero <= 1'b0;
            s1_uf   <= 1'b0;
        end else if (adv) begin
            s1_v    <= in_valid;
            s1_mant <= n1_mant;
            s1_exp  <= n1_exp;
            s1_sign <= sign;
            s1_rm   <= rmode_t'(rmode);
            s1_zero <= n1_zero;
            s1_uf   <= n1_uf;
        end
    end

    // ------------------------------------------------------------------
    // S2: round
    // ------------------------------------------------------------------
    logic                   g_bit, r_bit, s_bit, lsb_bit;
    logic                   r2_nx;
    logic                   r2_inc;
    logic                   frac_co;
    logic [MW-1:0]          frac_sum;
    logic [MW-1:0]          r2_frac;
    logic signed [XW-1:0]   r2_exp;

    // Decide the increment from the rounding mode and apply it to the fraction.
    always_comb begin
        g_bit   = s1_mant[2];
        r_bit   = s1_mant[1];
        s_bit   = s1_mant[0];
        lsb_bit = s1_mant[3];
        r2_nx   = g_bit | r_bit | s_bit;
        r2_inc  = 1'b0;
        case (s1_rm)
            RM_RNE:  r2_inc = g_bit & (r_bit | s_bit | lsb_bit);
            RM_RTZ:  r2_inc = 1'b0;
            RM_RUP:  r2_inc = r2_nx & !s1_sign;
            RM_RDN:  r2_inc = r2_nx & s1_sign;
            default: r2_inc = 1'b0;
        endcase
        {frac_co, frac_sum} = {1'b0, s1_mant[W-2:3]} + (MW+1)'(r2_inc);
        // A wrapped fraction ripples through the integer bit: 1.11..1 + ulp = 10.00..0
        r2_frac = frac_sum;
        r2_exp  = s1_exp;
        if (frac_co & s1_mant[W-1]) begin
            r2_exp = s1_exp + EXP_ONE;
        end
        if (s1_zero) begin
            r2_frac = '0;
            r2_exp  = '0;
        end
    end

    logic                   s2_v;
    logic [MW-1:0]          s2_frac;
    logic signed [XW-1:0]   s2_exp;
    logic                   s2_sign;
    rmode_t                 s2_rm;
    logic                   s2_nx;
    logic                   s2_zero;
    logic                   s2_uf;

    // S2 register: loads on adv, holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_frac <= '0;
            s2_exp  <= '0;
            s2_sign <= 1'b0;
            s2_rm   <= RM_RNE;
            s2_nx   <= 1'b0;
            s2_zero <= 1'b0;
            s2_uf   <= 1'b0;
        end else if (adv) begin
            s2_v    <= s1_v;
            s2_frac <= r2_frac;
            s2_exp  <= r2_exp;
            s2_sign <= s1_sign;
            s2_rm   <= s1_rm;
            s2_nx   <= r2_nx;
            s2_zero <= s1_zero;
            s2_uf   <= s1_uf;
        end
    end

    // ------------------------------------------------------------------
    // S3: pack and overflow check
    // ------------------------------------------------------------------
    logic                   p_of;
    logic                   p_to_inf;
    logic [EW-1:0]          p_e;
    logic [MW-1:0]          p_m;
    logic [3:0]             p_flg;

    // Saturate overflow to infinity or max finite depending on mode and sign.
    always_comb begin
        p_of     = !s2_zero && (s2_exp >= EXP_OF);
        p_to_inf = (s2_rm == RM_RNE) ||
                   ((s2_rm == RM_RUP) && !s2_sign) ||
                   ((s2_rm == RM_RDN) && s2_sign);
        p_e      = s2_exp[EW-1:0];
        p_m      = s2_frac;
        p_flg    = '0;
        p_flg[FLG_UF]   = s2_uf;
        p_flg[FLG_NX]   = s2_nx;
        p_flg[FLG_ZERO] = s2_zero;
        if (p_of) begin
            p_flg[FLG_OF] = 1'b1;
            p_flg[FLG_NX] = 1'b1;
            if (p_to_inf) begin
                p_e = '1;
                p_m = '0;
            end else begin
                p_e = EMAX;
                p_m = '1;
            end
        end
    end

    // Output register: loads on adv, holds stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            m         <= '0;
            e         <= '0;
            s_out     <= 1'b0;
            flg       <= '0;
        end else if (adv) begin
            out_valid <= s2_v;
            m         <= p_m;
            e         <= p_e;
            s_out     <= s2_sign;
            flg       <= p_flg;
        end
    end

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Bench for fp_norm_pipe: directed and random beats, scoreboard queue,
// negedge monitor, stalls from a selectable out_ready pattern, mid-stream reset.
module tb_fp_norm_pipe;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam int W  = MW + 4;
    localparam int RW = 1 + EW + MW + 4;   // {sign, e, m, flg}

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [EW-1:0]   es;
    logic            co;
    logic [W-1:0]    ms;
    logic            sign;
    logic [1:0]      rmode;
    logic            out_valid;
    logic            out_ready;
    logic [MW-1:0]   m;
    logic [EW-1:0]   e;
    logic            s_out;
    logic [3:0]      flg;

    fp_norm_pipe #(.EW(EW), .MW(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .es        (es),
        .co        (co),
        .ms        (ms),
        .sign      (sign),
        .rmode     (rmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m         (m),
        .e         (e),
        .s_out     (s_out),
        .flg       (flg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    logic [RW-1:0]   exp_q[$];
    int              ready_mode = 0;
    int              cyc = 0;
    logic            hold_pending = 1'b0;
    logic [RW-1:0]   held;

    function automatic logic [RW-1:0] mk(input logic s, input logic [EW-1:0] ev,
                                         input logic [MW-1:0] mv, input logic [3:0] f);
        return {s, ev, mv, f};
    endfunction

    // Reference: treat {co, ms} as a number with 3 guard bits, find its top bit,
    // scale it to 1.f form, round with plain integer comparisons, then range-check.
    function automatic logic [RW-1:0] model(input logic [EW-1:0] es_i, input logic co_i,
                                            input logic [W-1:0] ms_i, input logic sg,
                                            input logic [1:0] rm);
        longint v, nm, keep, rest;
        int p, ex;
        logic inc, of, uf, nx, zr;
        logic [EW-1:0] eo;
        logic [MW-1:0] mo;
        v = (longint'(co_i) << W) | longint'(ms_i);
        of = 0; uf = 0; nx = 0; zr = 0; eo = '0; mo = '0; inc = 0;
        if (v == 0) begin
            zr = 1;
        end else begin
            p = 0;
            for (int i = 0; i <= W; i++) if (v[i]) p = i;
            ex = int'(es_i) + p - (W - 1);
            if (p == W) nm = (v >> 1) | (v & 1);
            else        nm = v << ((W - 1) - p);
            rest = nm & 7;
            keep = nm >> 3;
            nx = (rest != 0);
            if (ex < 1) begin
                uf = 1; zr = 1;
            end else begin
                case (rm)
                    2'b00: inc = (rest > 4) || ((rest == 4) && keep[0]);
                    2'b01: inc = 0;
                    2'b10: inc = nx && !sg;
                    default: inc = nx && sg;
                endcase
                keep = keep + longint'(inc);
                if (keep == (longint'(1) << (MW + 1))) begin
                    keep = keep >> 1;
                    ex = ex + 1;
                end
                if (ex >= (1 << EW) - 1) begin
                    of = 1; nx = 1;
                    if (rm == 2'b00 || (rm == 2'b10 && !sg) || (rm == 2'b11 && sg)) begin
                        eo = '1; mo = '0;
                    end else begin
                        eo = EW'((1 << EW) - 2); mo = '1;
                    end
                end else begin
                    eo = ex[EW-1:0];
                    mo = keep[MW-1:0];
                end
            end
        end
        return {sg, eo, mo, of, uf, nx, zr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- out_ready pattern ----------------
    always @(posedge clk) begin
        cyc++;
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((cyc / 2) % 2) == 0;
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready_adv actual=%b required=%b", in_ready, !out_valid || out_ready);
            end
            if (hold_pending) begin
                checks++;
                if (out_valid !== 1'b1 || {s_out, e, m, flg} !== held) begin
                    errors++;
                    $display("FAIL hold_stable actual=%b/%h required=1/%h", out_valid, {s_out, e, m, flg}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", {s_out, e, m, flg});
                end else begin
                    logic [RW-1:0] x;
                    x = exp_q.pop_front();
                    if ({s_out, e, m, flg} !== x) begin
                        errors++;
                        $display("FAIL result actual s=%b e=%h m=%h flg=%b required s=%b e=%h m=%h flg=%b",
                                 s_out, e, m, flg, x[RW-1], x[RW-2 -: EW], x[MW+3:4], x[3:0]);
                    end
                end
            end
            hold_pending = out_valid && !out_ready;
            held = {s_out, e, m, flg};
        end
    end

    // ---------------- driver tasks ----------------
    // Entered at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input logic [EW-1:0] es_i, input logic co_i, input logic [W-1:0] ms_i,
                        input logic sg, input logic [1:0] rm, input logic [RW-1:0] expv);
        int n;
        n = 0;
        es = es_i; co = co_i; ms = ms_i; sign = sg; rmode = rm;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) break;
        end
        if (n > 1000) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted");
        end else begin
            exp_q.push_back(expv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [EW-1:0] r_es;
        logic          r_co, r_sg;
        logic [W-1:0]  r_ms;
        logic [1:0]    r_rm;
        r_es = EW'($urandom_range(0, (1 << EW) - 1));
        r_co = 1'($urandom_range(0, 1));
        r_ms = W'($urandom) >> $urandom_range(0, W - 1);
        if ($urandom_range(0, 15) == 0) r_ms = '0;
        r_sg = 1'($urandom_range(0, 1));
        r_rm = 2'($urandom_range(0, 3));
        send(r_es, r_co, r_ms, r_sg, r_rm, model(r_es, r_co, r_ms, r_sg, r_rm));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; es = '0; co = 1'b0; ms = '0; sign = 1'b0;
        rmode = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_m", 64'(m), 64'(0));
        chk("rst_e", 64'(e), 64'(0));
        chk("rst_s_out", 64'(s_out), 64'(0));
        chk("rst_flg", 64'(flg), 64'(0));
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed boundary cases with hand-derived results
        ready_mode = 0;
        send(8'h7F, 1'b0, 27'h4000000, 1'b0, 2'b00, mk(1'b0, 8'h7F, 23'h0, 4'b0000));
        send(8'h7F, 1'b0, 27'h2000000, 1'b0, 2'b00, mk(1'b0, 8'h7E, 23'h0, 4'b0000));
        send(8'h7F, 1'b1, 27'h7FFFFFF, 1'b0, 2'b00, mk(1'b0, 8'h81, 23'h0, 4'b0010));
        send(8'h7F, 1'b1, 27'h7FFFFFF, 1'b0, 2'b01, mk(1'b0, 8'h80, 23'h7FFFFF, 4'b0010));
        send(8'hFE, 1'b1, 27'h4000000, 1'b0, 2'b00, mk(1'b0, 8'hFF, 23'h0, 4'b1010));
        send(8'hFE, 1'b1, 27'h4000000, 1'b0, 2'b01, mk(1'b0, 8'hFE, 23'h7FFFFF, 4'b1010));
        send(8'hFE, 1'b1, 27'h4000000, 1'b1, 2'b10, mk(1'b1, 8'hFE, 23'h7FFFFF, 4'b1010));
        send(8'hFE, 1'b1, 27'h4000000, 1'b1, 2'b11, mk(1'b1, 8'hFF, 23'h0, 4'b1010));
        send(8'h55, 1'b0, 27'h0000000, 1'b1, 2'b00, mk(1'b1, 8'h00, 23'h0, 4'b0001));
        send(8'h02, 1'b0, 27'h0000008, 1'b0, 2'b00, mk(1'b0, 8'h00, 23'h0, 4'b0101));
        drain();

        // Back-to-back beats under a 2-on/2-off consumer
        ready_mode = 1;
        for (int i = 0; i < 10; i++) send_rand();
        drain();

        // Long random run with random stalls
        ready_mode = 2;
        for (int i = 0; i < 300; i++) send_rand();
        drain();

        // Reset with beats in flight: nothing may emerge afterwards
        ready_mode = 0;
        for (int i = 0; i < 3; i++) send_rand();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_flush_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_idle_valid", 64'(out_valid), 64'(0));
        chk("post_rst_queue", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
